// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, debug and LSU signal bundle around the data-memory arbiter.
// Revision 1.0
`default_nettype none

interface dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              core_req_i;
  logic              core_we_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic [3:0]        core_be_i;
  logic [2:0]        core_ld_sel_i;
  logic [31:0]       core_wdata_i;
  logic              core_stall_o;

  logic              dbg_valid_i;
  logic              dbg_lock_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [3:0]        dbg_be_i;
  logic [2:0]        dbg_ld_sel_i;
  logic [31:0]       dbg_wdata_i;
  logic              dbg_ready_o;
  logic [31:0]       dbg_rdata_o;
  logic              dbg_rvalid_o;

  logic              lsu_st_en_o;
  logic [ADDR_W-1:0] lsu_addr_o;
  logic [3:0]        lsu_be_o;
  logic [2:0]        lsu_ld_sel_o;
  logic [31:0]       lsu_st_data_o;
  logic [31:0]       lsu_ld_data_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_be_i, core_ld_sel_i, core_wdata_i,
    output core_stall_o,
    input  dbg_valid_i, dbg_lock_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_ld_sel_i, dbg_wdata_i,
    output dbg_ready_o, dbg_rdata_o, dbg_rvalid_o,
    output lsu_st_en_o, lsu_addr_o, lsu_be_o, lsu_ld_sel_o, lsu_st_data_o,
    input  lsu_ld_data_i
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_be_i, core_ld_sel_i, core_wdata_i,
    input  core_stall_o,
    output dbg_valid_i, dbg_lock_i, dbg_we_i, dbg_addr_i, dbg_be_i, dbg_ld_sel_i, dbg_wdata_i,
    input  dbg_ready_o, dbg_rdata_o, dbg_rvalid_o,
    input  lsu_st_en_o, lsu_addr_o, lsu_be_o, lsu_ld_sel_o, lsu_st_data_o,
    output lsu_ld_data_i
  );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +--------------------------------------------------------------------------+
// | dmem_arbiter: shares the LSU port between the MEM stage and a debug bus;  |
// | core has priority, starved debug gets a forced slot after MAX_WAIT.       |
// | Optional exclusive debug lock: define DMEM_ARB_LOCK_EN.                   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 12
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_CORE = 2'd0,
    S_DBG  = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] rdata_q;
  logic        rvalid_q;

  logic        lock_req;
  logic        owner_dbg;
  logic        ready;
  logic        stall;
  logic        conflict;
  logic        accept;
  logic        use_dbg;
  logic        use_core;
  logic [ADDR_W-1:0] addr_mux;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_req = bus.dbg_lock_i;
`else
  logic unused_lock;
  assign lock_req    = 1'b0;
  assign unused_lock = bus.dbg_lock_i;
`endif

  assign conflict = bus.core_req_i & bus.dbg_valid_i;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    owner_dbg = 1'b0;
    ready     = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      S_CORE: begin
        owner_dbg = ~bus.core_req_i & bus.dbg_valid_i;
        ready     = bus.dbg_valid_i & ~bus.core_req_i;
        // Outside a conflict the request is either absent or accepted, both clear the count
        if (conflict) begin
          if (wait_q == WAIT_LAST) begin
            state_d = S_DBG;
            wait_d  = 8'd0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end else begin
          wait_d = 8'd0;
        end
      end
      S_DBG: begin
        owner_dbg = 1'b1;
        ready     = 1'b1;
        stall     = bus.core_req_i;
        state_d   = S_CORE;
        wait_d    = 8'd0;
      end
      S_LOCK: begin
        owner_dbg = 1'b1;
        ready     = 1'b1;
        stall     = bus.core_req_i;
        wait_d    = 8'd0;
        if (!lock_req) state_d = S_CORE;
      end
      default: begin
        state_d = S_CORE;
        wait_d  = 8'd0;
      end
    endcase
    if (bus.dbg_valid_i && ready && lock_req) state_d = S_LOCK;
  end

  assign accept = bus.dbg_valid_i & ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_CORE;
      wait_q   <= 8'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      rvalid_q <= accept & ~bus.dbg_we_i;
      if (accept && !bus.dbg_we_i) rdata_q <= bus.lsu_ld_data_i;
    end
  end

  // An owner without a live request leaves the port idle on the core fields
  assign use_dbg  = owner_dbg & bus.dbg_valid_i;
  assign use_core = ~owner_dbg & bus.core_req_i;
  assign addr_mux = use_dbg ? bus.dbg_addr_i : bus.core_addr_i;

  assign bus.lsu_addr_o    = addr_mux;
  assign bus.lsu_be_o      = use_dbg ? bus.dbg_be_i     : bus.core_be_i;
  assign bus.lsu_ld_sel_o  = use_dbg ? bus.dbg_ld_sel_i : bus.core_ld_sel_i;
  assign bus.lsu_st_data_o = use_dbg ? bus.dbg_wdata_i  : bus.core_wdata_i;
  assign bus.lsu_st_en_o   = rst_ni & ((use_dbg & bus.dbg_we_i) | (use_core & bus.core_we_i));

  assign bus.dbg_ready_o   = rst_ni & ready;
  assign bus.core_stall_o  = rst_ni & stall;
  assign bus.dbg_rdata_o   = rdata_q;
  assign bus.dbg_rvalid_o  = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter with MAX_WAIT=4 and a word memory behind the LSU.
// Revision 1.0
`default_nettype none

module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;

  logic [31:0] mem [0:1023];

  dmem_arbiter_if #(.ADDR_W(12)) bus ();

  dmem_arbiter #(.MAX_WAIT(4), .ADDR_W(12)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.lsu_ld_data_i = mem[bus.lsu_addr_o[11:2]];

  always @(posedge clk) begin
    if (bus.lsu_st_en_o) mem[bus.lsu_addr_o[11:2]] <= bus.lsu_st_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst_n  = 1'b0;
    bus.core_req_i    = 1'b0;
    bus.core_we_i     = 1'b0;
    bus.core_addr_i   = '0;
    bus.core_be_i     = 4'hF;
    bus.core_ld_sel_i = 3'd2;
    bus.core_wdata_i  = '0;
    bus.dbg_valid_i   = 1'b1;
    bus.dbg_lock_i    = 1'b0;
    bus.dbg_we_i      = 1'b1;
    bus.dbg_addr_i    = 12'h010;
    bus.dbg_be_i      = 4'hF;
    bus.dbg_ld_sel_i  = 3'd2;
    bus.dbg_wdata_i   = 32'hDEADBEEF;

    // Reset held with a pending debug write
    tick(); tick(); #1;
    check("rst_ready",  {31'd0, bus.dbg_ready_o},  32'd0);
    check("rst_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
    check("rst_st_en",  {31'd0, bus.lsu_st_en_o},  32'd0);
    check("rst_stall",  {31'd0, bus.core_stall_o}, 32'd0);
    check("rst_rdata",  bus.dbg_rdata_o,           32'd0);

    // Release: first idle cycle fills with the debug write
    rst_n = 1'b1; #1;
    check("fill_ready",  {31'd0, bus.dbg_ready_o},  32'd1);
    check("fill_st_en",  {31'd0, bus.lsu_st_en_o},  32'd1);
    check("fill_addr",   {20'd0, bus.lsu_addr_o},   32'h010);
    check("fill_data",   bus.lsu_st_data_o,         32'hDEADBEEF);
    check("fill_be",     {28'd0, bus.lsu_be_o},     32'hF);
    check("fill_stall",  {31'd0, bus.core_stall_o}, 32'd0);
    tick();

    // Core store of the read-test pattern
    bus.dbg_valid_i  = 1'b0;
    bus.core_req_i   = 1'b1;
    bus.core_we_i    = 1'b1;
    bus.core_addr_i  = 12'h020;
    bus.core_wdata_i = 32'h12345678;
    #1;
    check("wr_no_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
    check("core_st_en",   {31'd0, bus.lsu_st_en_o},  32'd1);
    check("core_addr",    {20'd0, bus.lsu_addr_o},   32'h020);
    check("core_data",    bus.lsu_st_data_o,         32'h12345678);
    check("core_stall",   {31'd0, bus.core_stall_o}, 32'd0);
    tick();

    // Debug read of 0x020
    bus.core_req_i  = 1'b0;
    bus.core_we_i   = 1'b0;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = 12'h020;
    #1;
    check("rd_ready", {31'd0, bus.dbg_ready_o}, 32'd1);
    check("rd_st_en", {31'd0, bus.lsu_st_en_o}, 32'd0);
    check("rd_addr",  {20'd0, bus.lsu_addr_o},  32'h020);
    tick();
    bus.dbg_valid_i = 1'b0;
    #1;
    check("rd_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd1);
    check("rd_rdata",  bus.dbg_rdata_o,           32'h12345678);
    tick(); #1;
    check("rd_rvalid_pulse", {31'd0, bus.dbg_rvalid_o}, 32'd0);

    // Read back the idle-fill write
    bus.dbg_valid_i = 1'b1;
    bus.dbg_addr_i  = 12'h010;
    tick();
    bus.dbg_valid_i = 1'b0;
    #1;
    check("rb_rdata", bus.dbg_rdata_o, 32'hDEADBEEF);

    // Starvation: continuous core load against a debug write
    bus.core_req_i  = 1'b1;
    bus.core_we_i   = 1'b0;
    bus.core_addr_i = 12'h100;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_addr_i  = 12'h200;
    bus.dbg_wdata_i = 32'hA5A5A5A5;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("starve_stall_c%0d", c), {31'd0, bus.core_stall_o}, 32'd0);
      check($sformatf("starve_ready_c%0d", c), {31'd0, bus.dbg_ready_o},  32'd0);
      check($sformatf("starve_addr_c%0d", c),  {20'd0, bus.lsu_addr_o},   32'h100);
      tick();
    end
    #1;
    check("forced_stall", {31'd0, bus.core_stall_o}, 32'd1);
    check("forced_ready", {31'd0, bus.dbg_ready_o},  32'd1);
    check("forced_st_en", {31'd0, bus.lsu_st_en_o},  32'd1);
    check("forced_addr",  {20'd0, bus.lsu_addr_o},   32'h200);
    tick();
    bus.dbg_valid_i = 1'b0;
    #1;
    check("resume_stall", {31'd0, bus.core_stall_o}, 32'd0);
    check("resume_addr",  {20'd0, bus.lsu_addr_o},   32'h100);
    check("resume_st_en", {31'd0, bus.lsu_st_en_o},  32'd0);
    tick();

    // Confirm the forced write landed
    bus.core_req_i  = 1'b0;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = 12'h200;
    tick();
    bus.dbg_valid_i = 1'b0;
    #1;
    check("forced_rb_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd1);
    check("forced_rb_rdata",  bus.dbg_rdata_o,           32'hA5A5A5A5);

    // Forced slot wasted when debug drops its request
    bus.core_req_i  = 1'b1;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_addr_i  = 12'h300;
    bus.dbg_wdata_i = 32'h11111111;
    repeat (4) tick();
    bus.core_req_i  = 1'b0;
    bus.dbg_valid_i = 1'b0;
    #1;
    check("waste_stall", {31'd0, bus.core_stall_o}, 32'd0);
    check("waste_st_en", {31'd0, bus.lsu_st_en_o},  32'd0);
    check("waste_ready", {31'd0, bus.dbg_ready_o},  32'd1);
    tick();
    bus.core_req_i  = 1'b1;
    bus.dbg_valid_i = 1'b1;
    #1;
    check("waste_back_stall", {31'd0, bus.core_stall_o}, 32'd0);
    check("waste_back_ready", {31'd0, bus.dbg_ready_o},  32'd0);
    tick();
    bus.core_req_i  = 1'b0;
    bus.dbg_valid_i = 1'b0;
    tick();

`ifdef DMEM_ARB_LOCK_EN
    // Locked ownership across three conflicting requests
    bus.dbg_valid_i = 1'b1;
    bus.dbg_lock_i  = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_addr_i  = 12'h040;
    bus.dbg_wdata_i = 32'h00000001;
    #1;
    check("lock_ready", {31'd0, bus.dbg_ready_o}, 32'd1);
    tick();
    bus.core_req_i = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      #1;
      check($sformatf("lock_stall_r%0d", r), {31'd0, bus.core_stall_o}, 32'd1);
      check($sformatf("lock_ready_r%0d", r), {31'd0, bus.dbg_ready_o},  32'd1);
      check($sformatf("lock_addr_r%0d", r),  {20'd0, bus.lsu_addr_o},   32'h040);
      tick();
    end
    bus.dbg_lock_i  = 1'b0;
    bus.dbg_valid_i = 1'b0;
    #1;
    check("unlock_stall_last", {31'd0, bus.core_stall_o}, 32'd1);
    tick(); #1;
    check("unlock_core_stall", {31'd0, bus.core_stall_o}, 32'd0);
    check("unlock_core_addr",  {20'd0, bus.lsu_addr_o},   32'h100);
    tick();

    // Reset while locked
    bus.core_req_i  = 1'b0;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_lock_i  = 1'b1;
    tick();
    bus.core_req_i  = 1'b1;
    bus.dbg_valid_i = 1'b0;
    #1;
    check("lockrst_pre_stall", {31'd0, bus.core_stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("lockrst_stall", {31'd0, bus.core_stall_o}, 32'd0);
    tick();
    bus.dbg_lock_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("lockrst_after_stall", {31'd0, bus.core_stall_o}, 32'd0);
    tick();
`else
    // Lock request has no effect in this build
    bus.dbg_valid_i = 1'b1;
    bus.dbg_lock_i  = 1'b1;
    bus.dbg_we_i    = 1'b1;
    bus.dbg_addr_i  = 12'h040;
    #1;
    tick();
    bus.core_req_i = 1'b1;
    #1;
    check("nolock_stall", {31'd0, bus.core_stall_o}, 32'd0);
    check("nolock_ready", {31'd0, bus.dbg_ready_o},  32'd0);
    check("nolock_addr",  {20'd0, bus.lsu_addr_o},   32'h100);
    tick();
    bus.dbg_valid_i = 1'b0;
    bus.dbg_lock_i  = 1'b0;
    tick();
`endif

    // Reset with a read return pending
    bus.core_req_i  = 1'b0;
    bus.dbg_lock_i  = 1'b0;
    bus.dbg_valid_i = 1'b1;
    bus.dbg_we_i    = 1'b0;
    bus.dbg_addr_i  = 12'h020;
    tick();
    bus.dbg_valid_i = 1'b0;
    #1;
    check("rdrst_pre_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rdrst_rvalid", {31'd0, bus.dbg_rvalid_o}, 32'd0);
    check("rdrst_rdata",  bus.dbg_rdata_o,           32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory/LSU port between the pipeline MEM stage and a debug/loader bus. The pipeline has priority. The debug bus fills idle MEM-stage slots, and a starvation counter forces a debug slot, stalling the core, after `MAX_WAIT` conflicting cycles. The block sits between the execute/memory pipeline register outputs and the LSU. It drives the LSU control/address/data pins and a stall back to the hazard unit.

## Interface
Parameters:
- `MAX_WAIT`, default 4: conflicting cycles a pending debug request tolerates before a forced debug slot; legal range 1..255.
- `ADDR_W`, default 12: LSU byte-address width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `core_req_i` in 1: MEM stage performs a load or store this cycle.
- `core_we_i`, `core_addr_i[ADDR_W-1:0]`, `core_be_i[3:0]`, `core_ld_sel_i[2:0]`, `core_wdata_i[31:0]` in: MEM-stage access fields.
- `core_stall_o` out 1: MEM-stage access not performed this cycle; hold the M/W pipeline.
- `dbg_valid_i` in 1: debug request valid; held with fields stable until accepted.
- `dbg_lock_i` in 1: debug requests exclusive ownership (only with `DMEM_ARB_LOCK_EN`).
- `dbg_we_i`, `dbg_addr_i[ADDR_W-1:0]`, `dbg_be_i[3:0]`, `dbg_ld_sel_i[2:0]`, `dbg_wdata_i[31:0]` in: debug access fields.
- `dbg_ready_o` out 1: debug request accepted this cycle (`dbg_valid_i & dbg_ready_o`).
- `dbg_rdata_o` out 32: registered read data.
- `dbg_rvalid_o` out 1: one-cycle pulse; `dbg_rdata_o` valid.
- `lsu_st_en_o`, `lsu_addr_o[ADDR_W-1:0]`, `lsu_be_o[3:0]`, `lsu_ld_sel_o[2:0]`, `lsu_st_data_o[31:0]` out: to LSU.
- `lsu_ld_data_i` in 32: LSU combinational read data, same cycle as address.

## Operation
- Owner each cycle is CORE or DBG. The LSU mux selects the owner's fields. `lsu_st_en_o` = owner `we` & owner request; otherwise all outputs come from the core fields with `st_en` = 0.
- States:
  - S_CORE: owner = CORE if `core_req_i`, else DBG when `dbg_valid_i` (idle-slot fill). `dbg_ready_o` = `dbg_valid_i & ~core_req_i`. `core_stall_o` = 0.
  - S_DBG: owner = DBG. `dbg_ready_o` = 1. `core_stall_o` = `core_req_i`. Next state is always S_CORE (single forced slot).
  - S_LOCK: owner = DBG. `dbg_ready_o` = 1. `core_stall_o` = `core_req_i`. Exits to S_CORE when `dbg_lock_i` = 0.
- Wait counter (8 bit):
  - Increments in S_CORE on a conflict (`core_req_i & dbg_valid_i`).
  - Clears on any debug acceptance or when `dbg_valid_i` = 0.
  - S_CORE → S_DBG when a conflict occurs and count = `MAX_WAIT`-1; counter cleared.
- Lock entry: in S_CORE or S_DBG, a debug acceptance with `dbg_lock_i` = 1 moves to S_LOCK.
- Read return: a debug acceptance with `dbg_we_i` = 0 captures `lsu_ld_data_i` into `dbg_rdata_o`, and `dbg_rvalid_o` = 1 the next cycle. Debug writes produce no rvalid.
- Core load data is taken by the pipeline directly from the LSU. The arbiter never delays it beyond the stall.

## Timing
- Reset values: state S_CORE, counter 0, `dbg_rdata_o` 0, `dbg_rvalid_o` 0. Combinational outputs follow from S_CORE with inputs low: `core_stall_o` 0, `dbg_ready_o` 0, `lsu_st_en_o` 0.
- Latencies:
  - `dbg_ready_o`, `core_stall_o` and the LSU mux are combinational from state and inputs.
  - Debug read latency is 1 cycle from acceptance.
- Worst-case debug wait under continuous core traffic: `MAX_WAIT` cycles (accepted in cycle `MAX_WAIT`+1).
- `MAX_WAIT` = 1: first conflict cycle stalls nothing; the next cycle is S_DBG.
- `dbg_valid_i` dropping while in S_DBG: the slot is wasted, with no access and no stall if `core_req_i` = 0. Return to S_CORE.
- Reset asserted mid-lock or mid-read: immediate return to reset values; a pending `dbg_rvalid_o` is lost.
- A stalled core keeps `core_req_i` and its fields stable; the arbiter relies on this.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: S_LOCK and `dbg_lock_i` are active as described.
- Undefined: `dbg_lock_i` is ignored (port kept), S_LOCK is unreachable, and debug gets only idle or forced single slots.

## Test plan
- Reset: hold `rst_ni` = 0 with `dbg_valid_i` = 1 → `dbg_ready_o` = 0, `dbg_rvalid_o` = 0, `lsu_st_en_o` = 0. Release → first idle cycle accepts.
- Idle fill: `core_req_i` = 0, debug write addr 0x010, data 0xDEADBEEF, be 0xF → same-cycle `lsu_st_en_o` = 1, `lsu_addr_o` = 0x010, `core_stall_o` = 0.
- Debug read: preload 0x12345678 at 0x020, debug read → `dbg_rvalid_o` pulses one cycle later with `dbg_rdata_o` = 0x12345678.
- Starvation with `MAX_WAIT` = 4: `core_req_i` = 1 continuously and `dbg_valid_i` = 1 → cycles 1-4 core owns. Cycle 5: `core_stall_o` = 1 and `dbg_ready_o` = 1. Cycle 6: core resumes with the held access.
- Lock (`DMEM_ARB_LOCK_EN`): accept with `dbg_lock_i` = 1, then 3 more requests while `core_req_i` = 1 → `core_stall_o` = 1 for all of them. Drop lock → core owns the next cycle.
- Reset during S_LOCK → state S_CORE, `core_stall_o` = 0 at once.
